regfile_writer: RTL and testbench
=================================

# regfile_writer

Write-back end of the register-file interface. It merges fixed-latency ALU results with buffered results from variable-latency units (load, multi-cycle ops) onto the register file's single write port (wen/waddr/wdata). It also keeps a busy scoreboard of destinations that decode has reserved for variable-latency results, so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file.

## Interface
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 4, entries in the variable-latency result buffer; power of two, ≥2.
- STARVE_LIMIT, 8, cycles the FIFO head may be bypassed by ALU writes before drain_req asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  variable-latency result offered.
- mem_ready  out  1  buffer can accept a result.
- mem_rd  in  ADDR_WIDTH  variable-latency destination register.
- mem_data  in  DATA_WIDTH  variable-latency result.
- issue_valid  in  1  decode reserves issue_rd for a variable-latency result.
- issue_rd  in  ADDR_WIDTH  reserved destination register.
- busy_mask  out  2**ADDR_WIDTH  bit i set means register i has a pending variable-latency write.
- drain_req  out  1  request to execute to insert an ALU bubble.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current buffer occupancy.
- wen  out  1  register-file write enable (registered).
- waddr  out  ADDR_WIDTH  register-file write address (registered).
- wdata  out  DATA_WIDTH  register-file write data (registered).

## Operation
- Accept: mem_valid && mem_ready pushes {mem_rd, mem_data} into the FIFO. If mem_rd == 0, the handshake completes and nothing is pushed.
- mem_ready = !rst && (fifo_count < FIFO_DEPTH). It is computed from registered count only. A pop in the same cycle gives no credit.
- Write-port arbitration at each edge, in priority order:
  - alu_valid && alu_rd != 0: register the ALU result with wen=1.
  - Otherwise, FIFO non-empty: register the head with wen=1 and pop it.
  - Otherwise: wen=0; waddr/wdata hold their previous values.
- An ALU result with alu_rd == 0 is dropped and does not block a FIFO pop that cycle.
- Push and pop in the same edge: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy_mask[issue_rd].
  - A FIFO pop clears busy_mask[head rd].
  - Set and clear of the same bit in the same edge: the bit stays set.
  - ALU writes never touch busy_mask. busy_mask[0] is always 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each edge where the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
- drain_req = (fifo_count == FIFO_DEPTH) || (starve counter == STARVE_LIMIT). It is combinational from registered state.

## Timing
- Reset values: wen=0, waddr=0, wdata=0, FIFO empty, fifo_count=0, busy_mask=0, starve counter=0, drain_req=0, mem_ready=0 while rst is high.
- Reset mid-operation: all buffered entries and reservations are discarded. No write issues in the cycle after reset.
- ALU latency: result presented in cycle N appears as wen/waddr/wdata in cycle N+1.
- Variable-latency path into an empty FIFO with no ALU competition:
  - Handshake in cycle N, push at the end of N.
  - Pop at the end of N+1; wen high in cycle N+2.
- Scoreboard: a bit set by issue in cycle N is visible in cycle N+1. A bit cleared by a pop is visible in the same cycle that wen carries the write.
- FIFO full: mem_ready=0 and drain_req=1 from the cycle after the filling push. With one bubble, the pop frees a slot and mem_ready returns the following cycle.
- Throughput: one register write per cycle.

## Test plan
- Reset, then idle → wen=0, mem_ready=1, busy_mask=0, fifo_count=0, drain_req=0.
- alu_valid, rd=5, data=0xDEADBEEF in cycle N → wen=1, waddr=5, wdata=0xDEADBEEF in N+1; alu_rd=0 in N → wen=0 in N+1.
- issue rd=7, then mem result rd=7, data=0x1234 with ALU idle → busy_mask[7]=1 until the write; wen/waddr=7/0x1234 two cycles after the handshake, busy_mask[7]=0 in that same cycle.
- 4 mem pushes while alu_valid is held high → fifo_count=4, mem_ready=0, drain_req=1; drop alu_valid for one cycle → one pop, count=3, mem_ready=1 next cycle.
- One buffered entry plus ALU valid for 8 cycles → drain_req=1 after the 8th bypass; one ALU bubble → pop, counter clears, drain_req=0.
- Simultaneous issue and pop for rd=3 → busy_mask[3] stays 1. Assert rst with 2 entries buffered → next cycle fifo_count=0, busy_mask=0, wen=0.

Source files
------------

// File: rtl/regfile_writer.sv
// Write-back merge onto the register file's single write port: ALU results take
// priority, variable-latency results are buffered in a FIFO and drained in the gaps.
module regfile_writer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_WIDTH-1:0]         mem_rd,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic [(2**ADDR_WIDTH)-1:0]    busy_mask,
  output logic                          drain_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wen,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]         wdata
);

  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [ST_W-1:0]       starve_cnt;
  logic [NREG-1:0]       busy_next;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic                  alu_take, push, pop, fifo_empty;

  // mem handshake: a transfer happens on any edge where mem_valid && mem_ready;
  // mem_ready depends only on registered occupancy, so a same-cycle pop gives no credit.
  assign mem_ready  = !rst && (fifo_count < DEPTH_C);
  assign fifo_empty = (fifo_count == '0);
  assign alu_take   = alu_valid && (alu_rd != '0);
  assign push       = mem_valid && mem_ready && (mem_rd != '0);
  assign pop        = !alu_take && !fifo_empty;
  assign head_rd    = rd_q[rd_ptr];
  assign drain_req  = (fifo_count == DEPTH_C) || (starve_cnt == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= mem_rd;
      data_q[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue is applied after the pop clear so a same-edge set wins.
  always_comb begin
    busy_next = busy_mask;
    if (pop) busy_next[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= busy_next;
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_empty || pop) starve_cnt <= '0;
    else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + ST_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (alu_take) begin
      wen   <= 1'b1;
      waddr <= alu_rd;
      wdata <= alu_data;
    end else if (pop) begin
      wen   <= 1'b1;
      waddr <= head_rd;
      wdata <= data_q[rd_ptr];
    end else begin
      wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: ALU priority, FIFO buffering, scoreboard,
// starvation/full drain requests and reset flush.
module tb_regfile_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_mask;
  logic        drain_req;
  logic [2:0]  fifo_count;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;

  regfile_writer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_mask(busy_mask), .drain_req(drain_req), .fifo_count(fifo_count),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; issue_valid = 1'b0; issue_rd = '0;
    tick(); tick();
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_wen", wen, 0);

    // Idle after reset
    rst = 1'b0;
    tick();
    chk("idle_wen", wen, 0);
    chk("idle_waddr", waddr, 0);
    chk("idle_wdata", wdata, 0);
    chk("idle_mem_ready", mem_ready, 1);
    chk("idle_busy", busy_mask, 0);
    chk("idle_count", fifo_count, 0);
    chk("idle_drain", drain_req, 0);

    // ALU write, then ALU to r0 is dropped and waddr/wdata hold
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    chk("alu_wen", wen, 1);
    chk("alu_waddr", waddr, 5);
    chk("alu_wdata", wdata, 32'hDEADBEEF);
    alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    chk("alu_r0_wen", wen, 0);
    chk("alu_r0_waddr_hold", waddr, 5);
    chk("alu_r0_wdata_hold", wdata, 32'hDEADBEEF);
    alu_valid = 1'b0;

    // Reservation then variable-latency result for r7
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("sb_set", busy_mask, 32'h80);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
    tick();
    mem_valid = 1'b0;
    chk("mem_n1_wen", wen, 0);
    chk("mem_n1_busy", busy_mask, 32'h80);
    chk("mem_n1_count", fifo_count, 1);
    tick();
    chk("mem_n2_wen", wen, 1);
    chk("mem_n2_waddr", waddr, 7);
    chk("mem_n2_wdata", wdata, 32'h1234);
    chk("mem_n2_busy", busy_mask, 0);
    chk("mem_n2_count", fifo_count, 0);

    // Handshake to r0 completes without a push
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    chk("mem_r0_count", fifo_count, 0);
    tick();
    chk("mem_r0_wen", wen, 0);

    // Fill the FIFO under continuous ALU traffic; fifth offer is refused
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h900;
    mem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_rd = 5'(10 + i); mem_data = 32'hA0 + 32'(i);
      tick();
    end
    mem_valid = 1'b0;
    chk("full_count", fifo_count, 4);
    chk("full_mem_ready", mem_ready, 0);
    chk("full_drain", drain_req, 1);
    chk("full_alu_waddr", waddr, 9);
    alu_valid = 1'b0;
    tick();
    chk("bubble_wen", wen, 1);
    chk("bubble_waddr", waddr, 10);
    chk("bubble_wdata", wdata, 32'hA0);
    chk("bubble_count", fifo_count, 3);
    chk("bubble_mem_ready", mem_ready, 1);
    chk("bubble_drain", drain_req, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_order_waddr", waddr, 64'(10 + i));
      chk("drain_order_wdata", wdata, 64'(32'hA0 + 32'(i)));
    end
    chk("drained_count", fifo_count, 0);

    // Starvation: one entry bypassed by 8 ALU writes
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    mem_valid = 1'b0; issue_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("starve7_drain", drain_req, 0);
    tick();
    chk("starve8_drain", drain_req, 1);
    chk("starve8_count", fifo_count, 1);
    chk("starve8_busy", busy_mask, 32'h0010_0000);
    alu_valid = 1'b0;
    tick();
    chk("starve_pop_waddr", waddr, 20);
    chk("starve_pop_wdata", wdata, 32'h77);
    chk("starve_pop_drain", drain_req, 0);
    chk("starve_pop_busy", busy_mask, 0);

    // Simultaneous issue and pop of r3; ALU to r0 does not block the pop
    issue_valid = 1'b1; issue_rd = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0;
    chk("sim_wen", wen, 1);
    chk("sim_waddr", waddr, 3);
    chk("sim_wdata", wdata, 32'h33);
    chk("sim_busy", busy_mask, 32'h8);

    // Reset with two entries buffered
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    mem_valid = 1'b1; issue_valid = 1'b1;
    mem_rd = 5'd4; mem_data = 32'h44; issue_rd = 5'd4;
    tick();
    mem_rd = 5'd5; mem_data = 32'h45; issue_rd = 5'd5;
    tick();
    mem_valid = 1'b0; issue_valid = 1'b0;
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_busy", busy_mask, 32'h38);
    rst = 1'b1;
    tick();
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy_mask, 0);
    chk("mid_rst_wen", wen, 0);
    chk("mid_rst_mem_ready", mem_ready, 0);
    rst = 1'b0; alu_valid = 1'b0;
    tick();
    chk("post_rst_wen", wen, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_mem_ready", mem_ready, 1);
    chk("post_rst_drain", drain_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
